// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM/operand-class enums and the
// result record used by the iterative divider.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int N      = 1 + EXP_W + FRAC_W;
    localparam int BIAS   = 127;
    localparam int Q_BITS = FRAC_W + 3;

    localparam logic [N-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [N-1:0] INF  = {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_e;
    typedef enum logic [1:0] {C_ZERO, C_NORMAL, C_INF, C_NAN} fclass_e;

    typedef struct packed {
        logic [N-1:0] res;
        logic         ovf;
        logic         exc;
        logic         dbz;
    } fp_rsp_t;

    // Subnormals fall into C_ZERO: they are flushed before classification.
    function automatic fclass_e fp_classify(input logic [N-1:0] x);
        if (x[N-2:FRAC_W] == '0) return C_ZERO;
        if (x[N-2:FRAC_W] != '1) return C_NORMAL;
        return (x[FRAC_W-1:0] == '0) ? C_INF : C_NAN;
    endfunction
endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring-division step: compare/subtract the divisor, emit the
// quotient bit and the shifted partial remainder.
module fp_mant_div_step #(
    parameter int MW = 24
) (
    input  logic [MW:0]   rem_i,
    input  logic [MW-1:0] div_i,
    output logic [MW:0]   rem_o,
    output logic          qbit_o
);
    logic [MW:0] diff;

    // rem < 2*div holds on entry, so the shifted value never loses its MSB.
    always_comb begin
        diff   = rem_i - {1'b0, div_i};
        qbit_o = (rem_i >= {1'b0, div_i});
        rem_o  = (qbit_o ? diff : rem_i) << 1;
    end
endmodule

// File: rtl/fp_iterative_divider.sv
// Sequential IEEE-754 single-precision divider, one quotient bit per cycle.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise truncates.
module fp_iterative_divider
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic [N-1:0] inputA,
    input  logic [N-1:0] inputB,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         exception,
    output logic         div_by_zero
);
    localparam int MW = FRAC_W + 1;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(Q_BITS);
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MW:0]       rem_q, rem_d;
    logic [MW-1:0]     div_q, div_d;
    logic [Q_BITS-1:0] quo_q, quo_d;
    logic              sign_q, sign_d;
    logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
    fclass_e           ca_q, ca_d, cb_q, cb_d;
    fp_rsp_t           pend_q, pend_d, out_q, out_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [MW:0] step_rem;
    logic        step_qbit;

    fp_mant_div_step #(.MW(MW)) u_step (
        .rem_i  (rem_q),
        .div_i  (div_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    logic signed [EW-1:0] ea_s, eb_s, n_exp, n_exp_r;
    logic [MW-1:0]        n_mant;
    logic [MW:0]          n_rnd;
    logic [FRAC_W-1:0]    n_frac;
    logic                 n_guard, n_sticky, n_inc;
    fp_rsp_t              n_rsp;

    assign ea_s = {2'b00, ea_q};
    assign eb_s = {2'b00, eb_q};

    always_comb begin
        n_sticky = |rem_q;
        if (quo_q[Q_BITS-1]) begin
            n_mant   = quo_q[Q_BITS-1:2];
            n_guard  = quo_q[1];
            n_sticky = n_sticky | quo_q[0];
            n_exp    = ea_s - eb_s + BIAS_S;
        end else begin
            n_mant   = quo_q[Q_BITS-2:1];
            n_guard  = quo_q[0];
            n_exp    = ea_s - eb_s + BIAS_S - ONE_S;
        end
`ifdef FP_DIV_ROUND_EN
        n_inc = n_guard & (n_sticky | n_mant[0]);
`else
        n_inc = 1'b0;
`endif
        n_rnd = {1'b0, n_mant} + {{MW{1'b0}}, n_inc};
        // A carry out to 2^24 renormalizes: the fraction becomes all zeros.
        if (n_rnd[MW]) begin
            n_frac  = n_rnd[FRAC_W:1];
            n_exp_r = n_exp + ONE_S;
        end else begin
            n_frac  = n_rnd[FRAC_W-1:0];
            n_exp_r = n_exp;
        end

        n_rsp = '0;
        if (ca_q == C_NAN || cb_q == C_NAN || (ca_q == C_ZERO && cb_q == C_ZERO) ||
            (ca_q == C_INF && cb_q == C_INF)) begin
            n_rsp.res = QNAN;
            n_rsp.exc = 1'b1;
        end else if (ca_q == C_INF) begin
            n_rsp.res = {sign_q, INF[N-2:0]};
        end else if (cb_q == C_ZERO) begin
            n_rsp.res = {sign_q, INF[N-2:0]};
            n_rsp.dbz = 1'b1;
        end else if (cb_q == C_INF || ca_q == C_ZERO) begin
            n_rsp.res = {sign_q, {(N-1){1'b0}}};
        end else if (!n_exp_r[EW-1] && n_exp_r >= EMAX) begin
            n_rsp.res = {sign_q, INF[N-2:0]};
            n_rsp.ovf = 1'b1;
        end else if (n_exp_r[EW-1] || n_exp_r == '0) begin
            n_rsp.res = {sign_q, {(N-1){1'b0}}};
        end else begin
            n_rsp.res = {sign_q, n_exp_r[EXP_W-1:0], n_frac};
        end
    end

`ifndef FP_DIV_ROUND_EN
    logic rnd_unused;
    assign rnd_unused = n_guard ^ n_sticky;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        pend_d  = pend_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A start seen while done is still up is dropped.
                if (start && !done_q) begin
                    sign_d  = inputA[N-1] ^ inputB[N-1];
                    ea_d    = inputA[N-2:FRAC_W];
                    eb_d    = inputB[N-2:FRAC_W];
                    ca_d    = fp_classify(inputA);
                    cb_d    = fp_classify(inputB);
                    rem_d   = {2'b01, inputA[FRAC_W-1:0]};
                    div_d   = {1'b1, inputB[FRAC_W-1:0]};
                    quo_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = step_rem;
                quo_d = {quo_q[Q_BITS-2:0], step_qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(Q_BITS - 1)) state_d = S_NORM;
            end
            S_NORM: begin
                pend_d  = n_rsp;
                state_d = S_DONE;
            end
            S_DONE: begin
                out_d   = pend_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ca_q    <= C_ZERO;
            cb_q    <= C_ZERO;
            pend_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = out_q.res;
    assign overflow    = out_q.ovf;
    assign exception   = out_q.exc;
    assign div_by_zero = out_q.dbz;
endmodule

// File: tb/tb_fp_iterative_divider.sv
// Self-checking bench for fp_iterative_divider: directed cases, handshake
// control scenarios and random operands against an arithmetic model.
module tb_fp_iterative_divider;
    logic        clk = 1'b0;
    logic        reset, en, start;
    logic [31:0] inputA, inputB, result;
    logic        busy, done, overflow, exception, div_by_zero;
    int          n_pass = 0, n_total = 0, n_fail = 0;

    fp_iterative_divider dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .inputA(inputA), .inputB(inputB), .busy(busy), .done(done),
        .result(result), .overflow(overflow), .exception(exception),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Quotient from an exact integer division of the significands.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o,
                                    output logic x, output logic z);
        bit s = a[31] ^ b[31];
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        bit an = (ea == 255) && (a[22:0] != 0);
        bit bn = (eb == 255) && (b[22:0] != 0);
        bit ai = (ea == 255) && (a[22:0] == 0);
        bit bi = (eb == 255) && (b[22:0] == 0);
        bit az = (ea == 0);
        bit bz = (eb == 0);
        longint unsigned ma, mb, num, q, rm, mant;
        int sh, e;
        o = 0; x = 0; z = 0; r = 32'h0;
        if (an || bn || (az && bz) || (ai && bi)) begin r = 32'h7FC00000; x = 1; return; end
        if (ai) begin r = {s, 8'hFF, 23'd0}; return; end
        if (bz) begin r = {s, 8'hFF, 23'd0}; z = 1; return; end
        if (bi || az) begin r = {s, 31'd0}; return; end
        ma = {40'd1, a[22:0]};
        mb = {40'd1, b[22:0]};
        num = ma << 30;
        q = num / mb;
        rm = num % mb;
        if (q >= (64'd1 << 30)) begin sh = 7; e = ea - eb + 127; end
        else begin sh = 6; e = ea - eb + 126; end
        mant = q >> sh;
`ifdef FP_DIV_ROUND_EN
        begin
            bit g = q[sh-1];
            bit st = ((q & ((64'd1 << (sh - 1)) - 1)) != 0) || (rm != 0);
            if (g && (st || mant[0])) mant++;
        end
`endif
        if (mant == (64'd1 << 24)) begin mant = mant >> 1; e++; end
        if (e >= 255) begin r = {s, 8'hFF, 23'd0}; o = 1; end
        else if (e <= 0) r = {s, 31'd0};
        else r = {s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] mk_operand();
        logic [31:0] v = $urandom;
        int k = $urandom_range(0, 11);
        case (k)
            0: v[30:23] = 8'd0;
            1: v[30:0] = {8'hFF, 23'd0};
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        if (k == 2 && v[22:0] == 0) v[0] = 1'b1;
        return v;
    endfunction

    // Leaves the caller in the cycle where done is high.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic eo, input logic ee, input logic ez);
        int cyc;
        bit busy_ok;
        @(negedge clk); inputA = a; inputB = b; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 0; busy_ok = 1;
        while (!done && cyc < 80) begin
            busy_ok &= busy;
            @(negedge clk); cyc++;
        end
        check({tag, "_lat"}, cyc, 28);
        check({tag, "_busy"}, {31'd0, busy_ok}, 1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_res"}, result, er);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, "_exc"}, {31'd0, exception}, {31'd0, ee});
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    initial begin
        logic [31:0] a, b, er;
        logic eo, ee, ez;
        int cyc;
        bit seen;
        reset = 1'b0; en = 1'b1; start = 1'b0; inputA = '0; inputB = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_res", result, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_exc", {31'd0, exception}, 0);
        check("rst_dbz", {31'd0, div_by_zero}, 0);
        reset = 1'b1;

        run_div("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0);
`ifdef FP_DIV_ROUND_EN
        run_div("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 0);
`else
        run_div("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 0);
`endif
        // start raised while done is high must not launch a divide
        inputA = 32'h3F800000; inputB = 32'h40000000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_in_done_ignored", {31'd0, busy}, 0);

        run_div("pos_div0", 32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, 1);
        run_div("neg_div0", 32'hBF800000, 32'h00000000, 32'hFF800000, 0, 0, 1);
        run_div("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 0, 1, 0);
        run_div("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 1, 0);
        run_div("inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 1, 0);
        run_div("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1, 0, 0);
        run_div("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 0, 0, 0);
        run_div("inf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0);
        run_div("fin_inf", 32'h40000000, 32'hFF800000, 32'h80000000, 0, 0, 0);
        run_div("subnorm_flush", 32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 0);
        run_div("neg_six", 32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 0);

        // start pulse in the middle of a divide
        @(negedge clk); inputA = 32'h40C00000; inputB = 32'h40000000; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 0;
        while (!done && cyc < 80) begin
            if (cyc == 5) begin start = 1'b1; inputA = 32'h3F800000; inputB = 32'h40400000; end
            else start = 1'b0;
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        check("intrude_lat", cyc, 28);
        check("intrude_res", result, 32'h40400000);
        @(negedge clk);
        check("intrude_no_queue", {31'd0, busy}, 0);

        // enable low for 7 cycles mid-divide, then hold during done
        @(negedge clk); inputA = 32'h40C00000; inputB = 32'h40000000; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 0;
        while (!done && cyc < 80) begin
            if (cyc == 3) en = 1'b0;
            if (cyc == 10) en = 1'b1;
            @(negedge clk); cyc++;
        end
        check("en_stall_lat", cyc, 35);
        check("en_stall_res", result, 32'h40400000);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("done_frozen", {31'd0, done}, 1);
        en = 1'b1;
        @(negedge clk);
        check("done_pulse_end", {31'd0, done}, 0);

        // reset mid-divide aborts without a done
        @(negedge clk); inputA = 32'h40C00000; inputB = 32'h40000000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_res", result, 0);
        check("abort_done", {31'd0, done}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", {31'd0, seen}, 0);

        for (int i = 0; i < 40; i++) begin
            a = mk_operand();
            b = mk_operand();
            ref_div(a, b, er, eo, ee, ez);
            run_div($sformatf("rand%0d_%h_%h", i, a, b), a, b, er, eo, ee, ez);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
